hart_scheduler: RTL and testbench

- Per-cycle issue scheduler for the multi-hart core.
- Tracks the run state of each hart: off, ready, blocked on memory, or draining.
- Picks one ready hart per cycle round-robin and drives a one-hot hart select to the pipeline's fetch/issue stage.
- Sits between the core's configuration/enable logic, the pipeline issue stage and the imem/dmem acknowledge paths.

---
 rtl/core_pkg.sv | 23 ++
 rtl/rr_picker.sv | 35 +++
 rtl/hart_scheduler.sv | 150 +++++++++++++++
 tb/tb_hart_scheduler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and helpers for the multi-hart core scheduler.
// The optional blocked-hart watchdog is enabled with HART_SCHED_WDOG_EN.
package core_pkg;

    typedef enum logic [1:0] {
        HART_OFF     = 2'd0,
        HART_READY   = 2'd1,
        HART_BLOCKED = 2'd2,
        HART_DRAIN   = 2'd3
    } hart_state_e;

    localparam int unsigned ONEHOT_W = 32;

    function automatic logic is_onehot(input logic [ONEHOT_W-1:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

    // BLOCKED and DRAIN both have an access outstanding.
    function automatic logic is_susp(input hart_state_e s);
        return (s == HART_BLOCKED) || (s == HART_DRAIN);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority one-hot selector: first requester at or after ptr,
// wrapping from N-1 to 0.
module rr_picker #(
    parameter int unsigned N = 4,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    int unsigned   w_idx;
    logic [PW-1:0] w_sel;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = 0;
        w_sel   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = 32'(ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            w_sel = PW'(w_idx);
            if (!any && req[w_sel]) begin
                any        = 1'b1;
                gnt[w_sel] = 1'b1;
                gnt_idx    = w_sel;
            end
        end
    end

endmodule

// File: rtl/hart_scheduler.sv
// Per-cycle round-robin issue scheduler tracking the run state of each hart.
// Optional per-hart blocked watchdog: define HART_SCHED_WDOG_EN.
module hart_scheduler
    import core_pkg::*;
#(
    parameter int unsigned NUM_HART   = 4,
    parameter int unsigned WDOG_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_HART-1:0] hart_en,
    input  logic                issue_ready,
    output logic                issue_valid,
    output logic [NUM_HART-1:0] issue_hart_sel,
    input  logic                block_valid,
    input  logic [NUM_HART-1:0] block_hart_sel,
    input  logic                wake_valid,
    input  logic [NUM_HART-1:0] wake_hart_sel,
    output logic [NUM_HART-1:0] hart_ready,
    output logic [NUM_HART-1:0] hart_blocked,
    output logic                err
`ifdef HART_SCHED_WDOG_EN
    ,
    output logic [NUM_HART-1:0] wdog_timeout
`endif
);

    localparam int unsigned PW = $clog2(NUM_HART);

    if (NUM_HART < 2 || WDOG_WIDTH < 1) begin : g_param_chk
        $error("hart_scheduler: illegal parameters");
    end

    hart_state_e         r_state     [NUM_HART];
    hart_state_e         w_state_nxt [NUM_HART];
    hart_state_e         w_after_wake;
    logic [PW-1:0]       r_rr_ptr;
    logic                r_err;
    logic                w_err_set;
    logic                w_wake_ok;
    logic                w_blk_ok;
    logic                w_blk_oh;
    logic                w_wake_oh;
    logic [NUM_HART-1:0] w_blk_hit;
    logic [NUM_HART-1:0] w_wake_hit;
    logic [PW-1:0]       w_gnt_idx;

    assign w_blk_oh   = is_onehot(32'(block_hart_sel));
    assign w_wake_oh  = is_onehot(32'(wake_hart_sel));
    assign w_blk_hit  = (block_valid && w_blk_oh) ? block_hart_sel : '0;
    assign w_wake_hit = (wake_valid && w_wake_oh) ? wake_hart_sel : '0;

    // Wake is resolved first, then block is judged against the post-wake
    // state; enable only acts when neither event applied.
    always_comb begin
        w_err_set    = (block_valid && !w_blk_oh) || (wake_valid && !w_wake_oh);
        w_wake_ok    = 1'b0;
        w_blk_ok     = 1'b0;
        w_after_wake = HART_OFF;
        for (int unsigned i = 0; i < NUM_HART; i++) begin
            w_state_nxt[i] = r_state[i];
            w_after_wake   = r_state[i];
            w_wake_ok      = 1'b0;
            w_blk_ok       = 1'b0;
            if (w_wake_hit[i]) begin
                case (r_state[i])
                    HART_BLOCKED: begin w_after_wake = HART_READY; w_wake_ok = 1'b1; end
                    HART_DRAIN:   begin w_after_wake = HART_OFF;   w_wake_ok = 1'b1; end
                    default:      w_err_set = 1'b1;
                endcase
            end
            if (w_blk_hit[i]) begin
                if (w_after_wake == HART_READY) w_blk_ok = 1'b1;
                else                            w_err_set = 1'b1;
            end
            if (w_blk_ok) begin
                w_state_nxt[i] = HART_BLOCKED;
            end else if (w_wake_ok) begin
                w_state_nxt[i] = w_after_wake;
            end else begin
                case (r_state[i])
                    HART_OFF:     if (hart_en[i])  w_state_nxt[i] = HART_READY;
                    HART_READY:   if (!hart_en[i]) w_state_nxt[i] = HART_OFF;
                    HART_BLOCKED: if (!hart_en[i]) w_state_nxt[i] = HART_DRAIN;
                    HART_DRAIN:   if (hart_en[i])  w_state_nxt[i] = HART_BLOCKED;
                    default:      w_state_nxt[i] = HART_OFF;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_HART; i++) r_state[i] <= HART_OFF;
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_HART; i++) r_state[i] <= w_state_nxt[i];
            r_err <= r_err | w_err_set;
            if (issue_valid && issue_ready) begin
                r_rr_ptr <= (w_gnt_idx == PW'(NUM_HART - 1)) ? '0 : w_gnt_idx + PW'(1);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_HART; i++) begin
            hart_ready[i]   = (r_state[i] == HART_READY);
            hart_blocked[i] = is_susp(r_state[i]);
        end
    end

    assign err = r_err;

    rr_picker #(.N(NUM_HART)) u_picker (
        .req     (hart_ready),
        .ptr     (r_rr_ptr),
        .gnt     (issue_hart_sel),
        .gnt_idx (w_gnt_idx),
        .any     (issue_valid)
    );

`ifdef HART_SCHED_WDOG_EN
    logic [WDOG_WIDTH-1:0] r_wdog    [NUM_HART];
    logic [NUM_HART-1:0]   w_restart;

    // A fresh suspension (including block right after a wake) restarts the count.
    always_comb begin
        for (int unsigned i = 0; i < NUM_HART; i++) begin
            w_restart[i]    = is_susp(w_state_nxt[i]) && (!is_susp(r_state[i]) || w_wake_hit[i]);
            wdog_timeout[i] = (r_wdog[i] == '1) && is_susp(r_state[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_HART; i++) r_wdog[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_HART; i++) begin
                if (w_restart[i]) begin
                    r_wdog[i] <= '0;
                end else if (is_susp(r_state[i]) && is_susp(w_state_nxt[i]) && (r_wdog[i] != '1)) begin
                    r_wdog[i] <= r_wdog[i] + WDOG_WIDTH'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_hart_scheduler.sv
// Directed bench for hart_scheduler (NUM_HART=4); watchdog section runs
// when HART_SCHED_WDOG_EN is defined.
module tb_hart_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] hart_en;
    logic       issue_ready;
    logic       issue_valid;
    logic [3:0] issue_hart_sel;
    logic       block_valid;
    logic [3:0] block_hart_sel;
    logic       wake_valid;
    logic [3:0] wake_hart_sel;
    logic [3:0] hart_ready;
    logic [3:0] hart_blocked;
    logic       err;
`ifdef HART_SCHED_WDOG_EN
    logic [3:0] wdog_timeout;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int blk1_cnt = 0;
    bit cnt_en   = 1'b0;

    hart_scheduler #(.NUM_HART(4), .WDOG_WIDTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .hart_en        (hart_en),
        .issue_ready    (issue_ready),
        .issue_valid    (issue_valid),
        .issue_hart_sel (issue_hart_sel),
        .block_valid    (block_valid),
        .block_hart_sel (block_hart_sel),
        .wake_valid     (wake_valid),
        .wake_hart_sel  (wake_hart_sel),
        .hart_ready     (hart_ready),
        .hart_blocked   (hart_blocked),
        .err            (err)
`ifdef HART_SCHED_WDOG_EN
        ,
        .wdog_timeout   (wdog_timeout)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        if (cnt_en && hart_blocked[1]) blk1_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [3:0] esel, input logic [3:0] eblk);
        chk({tag, "_sel"}, 32'(issue_hart_sel), 32'(esel));
        chk({tag, "_blk"}, 32'(hart_blocked), 32'(eblk));
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(issue_valid), 32'd0);
        chk({tag, "_sel"},   32'(issue_hart_sel), 32'd0);
        chk({tag, "_ready"}, 32'(hart_ready), 32'd0);
        chk({tag, "_blk"},   32'(hart_blocked), 32'd0);
        chk({tag, "_err"},   32'(err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; hart_en = '0; issue_ready = 1'b0;
        block_valid = 1'b0; block_hart_sel = '0;
        wake_valid = 1'b0; wake_hart_sel = '0;
        #2 rst = 1'b0;
        #1 chk_all_zero("in_rst");
        @(posedge clk); #1;
        rst = 1'b1; hart_en = 4'b1111; issue_ready = 1'b1;

        chk_all_zero("post_rst");
        step();

        // Round-robin
        cyc("rr0", 4'b0001, 4'b0000);
        cyc("rr1", 4'b0010, 4'b0000);
        cyc("rr2", 4'b0100, 4'b0000);
        cyc("rr3", 4'b1000, 4'b0000);
        cyc("rr4", 4'b0001, 4'b0000);
        cyc("rr5", 4'b0010, 4'b0000);

        // Backpressure holds the grant
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("bp_hold", 4'b0100, 4'b0000);
        issue_ready = 1'b1;
        cyc("bp_rel", 4'b0100, 4'b0000);
        cyc("bp_next", 4'b1000, 4'b0000);

        // Block hart 1 while it issues, wake it 5 cycles later
        cyc("bw0", 4'b0001, 4'b0000);
        block_valid = 1'b1; block_hart_sel = 4'b0010; cnt_en = 1'b1;
        cyc("bw_blk", 4'b0010, 4'b0000);
        block_valid = 1'b0; block_hart_sel = '0;
        cyc("bw1", 4'b0100, 4'b0010);
        cyc("bw2", 4'b1000, 4'b0010);
        cyc("bw3", 4'b0001, 4'b0010);
        cyc("bw4", 4'b0100, 4'b0010);
        wake_valid = 1'b1; wake_hart_sel = 4'b0010;
        cyc("bw_wake", 4'b1000, 4'b0010);
        wake_valid = 1'b0; wake_hart_sel = '0;
        cyc("bw5", 4'b0001, 4'b0000);
        cnt_en = 1'b0;
        chk("bw_blk_cycles", 32'(blk1_cnt), 32'd5);
        cyc("bw_back", 4'b0010, 4'b0000);

        // Drain: block hart 2, drop its enable, then wake
        block_valid = 1'b1; block_hart_sel = 4'b0100;
        cyc("dr_blk", 4'b0100, 4'b0000);
        block_valid = 1'b0; block_hart_sel = '0; hart_en = 4'b1011;
        cyc("dr0", 4'b1000, 4'b0100);
        wake_valid = 1'b1; wake_hart_sel = 4'b0100;
        chk("dr_ready", 32'(hart_ready), 32'(4'b1011));
        cyc("dr_drain", 4'b0001, 4'b0100);
        wake_valid = 1'b0; wake_hart_sel = '0;
        chk("dr_off_ready", 32'(hart_ready), 32'(4'b1011));
        cyc("dr1", 4'b0010, 4'b0000);
        cyc("dr2", 4'b1000, 4'b0000);
        cyc("dr3", 4'b0001, 4'b0000);
        cyc("dr4", 4'b0010, 4'b0000);
        cyc("dr5", 4'b1000, 4'b0000);

        // Simultaneous wake+block on blocked hart 3
        block_valid = 1'b1; block_hart_sel = 4'b1000;
        cyc("sm_blk", 4'b0001, 4'b0000);
        wake_valid = 1'b1; wake_hart_sel = 4'b1000;
        chk("sm_err0", 32'(err), 32'd0);
        cyc("sm_both", 4'b0010, 4'b1000);
        block_valid = 1'b0; block_hart_sel = '0;
        wake_valid = 1'b0; wake_hart_sel = '0;
        hart_en = 4'b1010;
        chk("sm_err1", 32'(err), 32'd0);
        chk("sm_ready", 32'(hart_ready), 32'(4'b0011));
        cyc("sm_stay", 4'b0001, 4'b1000);

        // Wake for OFF hart 0 is a protocol error
        wake_valid = 1'b1; wake_hart_sel = 4'b0001;
        chk("er_ready0", 32'(hart_ready), 32'(4'b0010));
        cyc("er_wake", 4'b0010, 4'b1000);
        wake_valid = 1'b0; wake_hart_sel = '0;
        chk("er_err", 32'(err), 32'd1);
        chk("er_ready1", 32'(hart_ready), 32'(4'b0010));
        cyc("er1", 4'b0010, 4'b1000);
        chk("er_sticky", 32'(err), 32'd1);
        chk("er_valid", 32'(issue_valid), 32'd1);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1 chk_all_zero("async_rst");
        hart_en = 4'b0001;
        @(posedge clk); #1;
        rst = 1'b1;

`ifdef HART_SCHED_WDOG_EN
        step();
        block_valid = 1'b1; block_hart_sel = 4'b0001;
        chk("wd_sel", 32'(issue_hart_sel), 32'(4'b0001));
        step();
        block_valid = 1'b0; block_hart_sel = '0;
        for (int k = 0; k < 15; k++) begin
            if (k == 14) chk("wd_pre", 32'(wdog_timeout), 32'd0);
            step();
        end
        chk("wd_to", 32'(wdog_timeout), 32'(4'b0001));
        chk("wd_blk", 32'(hart_blocked), 32'(4'b0001));
        wake_valid = 1'b1; wake_hart_sel = 4'b0001;
        step();
        wake_valid = 1'b0; wake_hart_sel = '0;
        chk("wd_clr", 32'(wdog_timeout), 32'd0);
        chk("wd_ready", 32'(hart_ready), 32'(4'b0001));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
